// File: rtl/qbox_pkg.sv
// Shared types, default geometry and helpers for the question box controller.
// Optional idle bob is enabled by defining QBOX_IDLE_FLOAT_EN.
package qbox_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RISE     = 3'd1,
    ST_FALL     = 3'd2,
    ST_REVEAL   = 3'd3,
    ST_COOLDOWN = 3'd4
  } qbox_state_t;

  localparam int DEFAULT_HOME_X = 320;
  localparam int DEFAULT_HOME_Y = 240;
  localparam int FLOAT_PERIOD   = 32;

  // Dice faces are 1..6; out-of-range encodings fall back to 1.
  function automatic logic [2:0] clamp_dice(input logic [2:0] raw);
    if (raw == 3'd0 || raw == 3'd7) begin
      return 3'd1;
    end
    return raw;
  endfunction

endpackage

// File: rtl/qbox_frame_timer.sv
// Loadable down-counter advanced by frame_tick; done flags the tick that
// consumes the last remaining frame.
module qbox_frame_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             frame_tick,
  output logic             done
);

  logic [WIDTH-1:0] count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      count_reg <= '0;
    end else if (load) begin
      count_reg <= load_value;
    end else if (frame_tick && count_reg != '0) begin
      count_reg <= count_reg - 1'b1;
    end
  end

  assign done = frame_tick && (count_reg == WIDTH'(1));

endmodule

// File: rtl/question_box_controller.sv
// Question box sequencer: accept a roll, bounce on frame ticks, reveal, cool down.
// Define QBOX_IDLE_FLOAT_EN for a one-pixel idle bob every FLOAT_PERIOD ticks.
module question_box_controller
  import qbox_pkg::*;
#(
  parameter int HOME_X          = DEFAULT_HOME_X,
  parameter int HOME_Y          = DEFAULT_HOME_Y,
  parameter int BOUNCE_HEIGHT   = 8,
  parameter int BOUNCE_STEP     = 2,
  parameter int REVEAL_FRAMES   = 60,
  parameter int COOLDOWN_FRAMES = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       hit_valid,
  output logic       hit_ready,
  input  logic [2:0] dice_value,
  output logic [9:0] box_x,
  output logic [9:0] box_y,
  output logic       show_value,
  output logic [2:0] value_out,
  output logic       value_valid,
  output logic       busy
);

  localparam int MAX_FRAMES = (REVEAL_FRAMES > COOLDOWN_FRAMES) ? REVEAL_FRAMES : COOLDOWN_FRAMES;
  localparam int CNT_W      = $clog2(MAX_FRAMES + 1);

  localparam logic [9:0] HOME_X_L = 10'(HOME_X);
  localparam logic [9:0] HOME_Y_L = 10'(HOME_Y);
  localparam logic [9:0] HEIGHT_L = 10'(BOUNCE_HEIGHT);
  localparam logic [9:0] STEP_L   = 10'(BOUNCE_STEP);

  qbox_state_t      state_reg, state_next;
  logic [9:0]       offset_reg, offset_next;
  logic             timer_load;
  logic [CNT_W-1:0] timer_value;
  logic             timer_done;
  logic             accept;

  assign accept = hit_valid && hit_ready;

  qbox_frame_timer #(
    .WIDTH(CNT_W)
  ) u_frame_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .frame_tick(frame_tick),
    .done      (timer_done)
  );

`ifdef QBOX_IDLE_FLOAT_EN
  localparam int FLOAT_W = $clog2(FLOAT_PERIOD);

  logic [FLOAT_W-1:0] float_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset || accept) begin
      float_cnt_reg <= '0;
    end else if (state_reg == ST_IDLE && frame_tick) begin
      float_cnt_reg <= float_cnt_reg + 1'b1;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_IDLE;
      offset_reg <= '0;
    end else begin
      state_reg  <= state_next;
      offset_reg <= offset_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    offset_next = offset_reg;
    timer_load  = 1'b0;
    timer_value = '0;
    case (state_reg)
      ST_IDLE: begin
        // A tick coincident with acceptance is deliberately not used for motion.
        if (accept) begin
          state_next  = ST_RISE;
          offset_next = '0;
        end
`ifdef QBOX_IDLE_FLOAT_EN
        else if (frame_tick && float_cnt_reg == FLOAT_W'(FLOAT_PERIOD - 1)) begin
          offset_next = {9'd0, ~offset_reg[0]};
        end
`endif
      end
      ST_RISE: begin
        if (frame_tick) begin
          if (offset_reg + STEP_L >= HEIGHT_L) begin
            offset_next = HEIGHT_L;
            state_next  = ST_FALL;
          end else begin
            offset_next = offset_reg + STEP_L;
          end
        end
      end
      ST_FALL: begin
        if (frame_tick) begin
          if (offset_reg <= STEP_L) begin
            offset_next = '0;
            state_next  = ST_REVEAL;
            timer_load  = 1'b1;
            timer_value = CNT_W'(REVEAL_FRAMES);
          end else begin
            offset_next = offset_reg - STEP_L;
          end
        end
      end
      ST_REVEAL: begin
        if (timer_done) begin
          state_next  = ST_COOLDOWN;
          timer_load  = 1'b1;
          timer_value = CNT_W'(COOLDOWN_FRAMES);
        end
      end
      ST_COOLDOWN: begin
        if (timer_done) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next  = ST_IDLE;
        offset_next = '0;
      end
    endcase
  end

  // Outputs are registered from the next state so they change with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      box_x       <= HOME_X_L;
      box_y       <= HOME_Y_L;
      show_value  <= 1'b0;
      value_out   <= 3'd1;
      value_valid <= 1'b0;
      busy        <= 1'b0;
      hit_ready   <= 1'b1;
    end else begin
      box_x       <= HOME_X_L;
      box_y       <= HOME_Y_L - offset_next;
      show_value  <= (state_next == ST_REVEAL);
      value_valid <= (state_next == ST_REVEAL) && (state_reg != ST_REVEAL);
      busy        <= (state_next != ST_IDLE);
      hit_ready   <= (state_next == ST_IDLE);
      if (accept) begin
        value_out <= clamp_dice(dice_value);
      end
    end
  end

endmodule

// File: tb/tb_question_box_controller.sv
// Directed bench for question_box_controller: vector table for the basic roll,
// hand sequences for reveal/cooldown timing, rejection, boundaries and reset.
module tb_question_box_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       frame_tick;
  logic       hit_valid;
  logic [2:0] dice_value;
  logic       hit_ready;
  logic [9:0] box_x;
  logic [9:0] box_y;
  logic       show_value;
  logic [2:0] value_out;
  logic       value_valid;
  logic       busy;

  logic       t7_tick;
  logic       t7_hv;
  logic [2:0] t7_dice;
  logic       t7_ready;
  logic [9:0] t7_x;
  logic [9:0] t7_y;
  logic       t7_show;
  logic [2:0] t7_val;
  logic       t7_vv;
  logic       t7_busy;

  question_box_controller u_dut (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (frame_tick),
    .hit_valid  (hit_valid),
    .hit_ready  (hit_ready),
    .dice_value (dice_value),
    .box_x      (box_x),
    .box_y      (box_y),
    .show_value (show_value),
    .value_out  (value_out),
    .value_valid(value_valid),
    .busy       (busy)
  );

  question_box_controller #(
    .BOUNCE_HEIGHT  (7),
    .BOUNCE_STEP    (2),
    .REVEAL_FRAMES  (3),
    .COOLDOWN_FRAMES(2)
  ) u_dut7 (
    .clk        (clk),
    .reset      (reset),
    .frame_tick (t7_tick),
    .hit_valid  (t7_hv),
    .hit_ready  (t7_ready),
    .dice_value (t7_dice),
    .box_x      (t7_x),
    .box_y      (t7_y),
    .show_value (t7_show),
    .value_out  (t7_val),
    .value_valid(t7_vv),
    .busy       (t7_busy)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input logic tick, input logic hv, input logic [2:0] d);
    frame_tick = tick;
    hit_valid  = hv;
    dice_value = d;
    @(posedge clk);
    #1;
  endtask

  task automatic step7(input logic tick, input logic hv, input logic [2:0] d);
    t7_tick = tick;
    t7_hv   = hv;
    t7_dice = d;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       tick;
    logic       hv;
    logic [2:0] dice;
    int         y;
    logic       show;
    logic       vv;
    logic [2:0] val;
    logic       busy;
    logic       ready;
  } vec_t;

  vec_t vecs[12];
  int   exp7[8];

  initial begin
    reset = 1'b1; frame_tick = 1'b0; hit_valid = 1'b0; dice_value = 3'd0;
    t7_tick = 1'b0; t7_hv = 1'b0; t7_dice = 3'd0;

    // Basic roll with dice 5; dice 3 held while busy must be ignored.
    vecs[0]  = '{1'b0, 1'b1, 3'd5, 240, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 3'd0, 238, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 3'd3, 238, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 3'd3, 236, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1'b1, 3'd3, 234, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 3'd0, 232, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 3'd0, 234, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 3'd0, 236, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 3'd0, 238, 1'b0, 1'b0, 3'd5, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 3'd0, 240, 1'b1, 1'b1, 3'd5, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 3'd3, 240, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b0, 3'd0, 240, 1'b1, 1'b0, 3'd5, 1'b1, 1'b0};
    exp7 = '{238, 236, 234, 233, 235, 237, 239, 240};

    // Reset state.
    step(1'b0, 1'b0, 3'd0);
    step(1'b0, 1'b0, 3'd0);
    $display("reset: box_x=%0d box_y=%0d ready=%0d busy=%0d", box_x, box_y, hit_ready, busy);
    check("reset box_y", box_y, 240);
    check("reset box_x", box_x, 320);
    check("reset hit_ready", hit_ready, 1);
    check("reset busy", busy, 0);
    check("reset show_value", show_value, 0);
    check("reset value_out", value_out, 1);
    check("reset value_valid", value_valid, 0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].tick, vecs[i].hv, vecs[i].dice);
      $display("vec %0d: tick=%0d hv=%0d dice=%0d -> y=%0d show=%0d vv=%0d val=%0d busy=%0d ready=%0d",
               i, vecs[i].tick, vecs[i].hv, vecs[i].dice, box_y, show_value, value_valid,
               value_out, busy, hit_ready);
      check($sformatf("vec%0d box_y", i), box_y, vecs[i].y);
      check($sformatf("vec%0d show_value", i), show_value, vecs[i].show);
      check($sformatf("vec%0d value_valid", i), value_valid, vecs[i].vv);
      check($sformatf("vec%0d value_out", i), value_out, vecs[i].val);
      check($sformatf("vec%0d busy", i), busy, vecs[i].busy);
      check($sformatf("vec%0d hit_ready", i), hit_ready, vecs[i].ready);
      check($sformatf("vec%0d box_x", i), box_x, 320);
    end

    // Reveal lasts exactly 60 ticks after landing.
    for (int i = 1; i <= 60; i++) begin
      step(1'b1, 1'b0, 3'd0);
      if (i == 59) check("reveal tick59 show_value", show_value, 1);
      if (i == 60) begin
        $display("reveal end: show=%0d busy=%0d ready=%0d", show_value, busy, hit_ready);
        check("reveal tick60 show_value", show_value, 0);
        check("reveal tick60 busy", busy, 1);
        check("reveal tick60 hit_ready", hit_ready, 0);
      end
    end

    // Cooldown of 30 ticks with a dice-3 hit held throughout.
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, 1'b1, 3'd3);
      if (i == 29) begin
        check("cool tick29 hit_ready", hit_ready, 0);
        check("cool tick29 value_out", value_out, 5);
      end
      if (i == 30) begin
        $display("cooldown end: ready=%0d busy=%0d val=%0d", hit_ready, busy, value_out);
        check("cool tick30 hit_ready", hit_ready, 1);
        check("cool tick30 busy", busy, 0);
        check("cool tick30 value_out", value_out, 5);
      end
    end
    step(1'b0, 1'b1, 3'd3);
    $display("held hit accepted: val=%0d busy=%0d ready=%0d", value_out, busy, hit_ready);
    check("held hit value_out", value_out, 3);
    check("held hit busy", busy, 1);
    check("held hit hit_ready", hit_ready, 0);

    // Reset during RISE, then dice 0 clamps to 1.
    reset = 1'b1;
    step(1'b0, 1'b0, 3'd0);
    reset = 1'b0;
    check("rise reset busy", busy, 0);
    check("rise reset value_out", value_out, 1);
    step(1'b0, 1'b1, 3'd0);
    $display("dice0: val=%0d busy=%0d", value_out, busy);
    check("dice0 value_out", value_out, 1);
    check("dice0 busy", busy, 1);

    // Hit coincident with a tick gives no motion on that tick.
    reset = 1'b1;
    step(1'b0, 1'b0, 3'd0);
    reset = 1'b0;
    step(1'b1, 1'b1, 3'd4);
    $display("hit+tick: y=%0d busy=%0d val=%0d", box_y, busy, value_out);
    check("hit+tick box_y", box_y, 240);
    check("hit+tick busy", busy, 1);
    check("hit+tick value_out", value_out, 4);
    step(1'b1, 1'b0, 3'd0);
    check("hit+tick next box_y", box_y, 238);
    step(1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0);
    step(1'b1, 1'b0, 3'd0);
    check("fall first box_y", box_y, 234);

    // Reset mid-FALL returns to rest in one cycle.
    reset = 1'b1;
    step(1'b0, 1'b0, 3'd0);
    reset = 1'b0;
    $display("fall reset: y=%0d show=%0d busy=%0d ready=%0d", box_y, show_value, busy, hit_ready);
    check("fall reset box_y", box_y, 240);
    check("fall reset show_value", show_value, 0);
    check("fall reset busy", busy, 0);
    check("fall reset hit_ready", hit_ready, 1);

    // Non-multiple height/step: 7/2 saturates at 7 and lands at 0.
    step7(1'b0, 1'b1, 3'd7);
    check("h7 dice7 value_out", t7_val, 1);
    for (int i = 0; i < 8; i++) begin
      step7(1'b1, 1'b0, 3'd0);
      $display("h7 tick %0d: y=%0d show=%0d vv=%0d", i + 1, t7_y, t7_show, t7_vv);
      check($sformatf("h7 tick%0d box_y", i + 1), t7_y, exp7[i]);
      check($sformatf("h7 tick%0d value_valid", i + 1), t7_vv, (i == 7) ? 1 : 0);
    end
    check("h7 landed show_value", t7_show, 1);
    step7(1'b1, 1'b0, 3'd0);
    step7(1'b1, 1'b0, 3'd0);
    check("h7 reveal2 show_value", t7_show, 1);
    step7(1'b1, 1'b0, 3'd0);
    check("h7 reveal3 show_value", t7_show, 0);
    step7(1'b1, 1'b0, 3'd0);
    check("h7 cool1 hit_ready", t7_ready, 0);
    step7(1'b1, 1'b0, 3'd0);
    check("h7 cool2 hit_ready", t7_ready, 1);
    step7(1'b0, 1'b0, 3'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
